// File: rtl/axis_if.sv
// axis_if: AXI-Stream bundle shared by the traffic generator and its sink.
// Master drives payload and tvalid; slave drives tready.
interface axis_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid, tdata, tlast, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axis_pattern_tg.sv
// axis_pattern_tg: Bernoulli-injection AXI-Stream traffic generator for mesh NoC tests.
// Define AXIS_TG_STALL_STATS_EN to build the tvalid && !tready stall counter.
module axis_pattern_tg #(
  parameter int          TDATA_WIDTH = 512,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          TID         = 0,
  parameter int          NUM_ROWS    = 2,
  parameter int          NUM_COLS    = 2,
  parameter int          COUNT_WIDTH = 32,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEST_SEED   = 16'd1,
  parameter logic [15:0] LOAD_SEED   = 16'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              load,
  input  logic [COUNT_WIDTH-1:0]   num_packets,
  input  logic [1:0]               pattern,
  input  logic [TDEST_WIDTH-1:0]   hotspot_dest,
  input  logic [7:0]               pkt_len,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   sent_packets,
  output logic [COUNT_WIDTH-1:0]   dropped,
  output logic [COUNT_WIDTH-1:0]   stall_cycles,
  axis_if.master                   axis_out
);
  localparam int HW    = TDATA_WIDTH / 2;
  localparam int N     = NUM_ROWS * NUM_COLS;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int MY_R  = TID / NUM_COLS;
  localparam int MY_C  = TID % NUM_COLS;
  localparam bit SQUARE = (NUM_ROWS == NUM_COLS);
  localparam logic [TDEST_WIDTH-1:0] TRANS_DEST =
    TDEST_WIDTH'(MY_C * NUM_COLS + MY_R);
  localparam logic [TDEST_WIDTH-1:0] NEIGH_DEST =
    TDEST_WIDTH'(MY_R * NUM_COLS + (MY_C + 1) % NUM_COLS);
  localparam logic [TDEST_WIDTH:0] N_W = (TDEST_WIDTH+1)'(N);
  localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]          POLY = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic [TDEST_WIDTH-1:0] dest;
    logic [COUNT_WIDTH-1:0] seq;
    logic [HW-1:0]          ts;
  } entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                 state_q, state_d;
  logic [15:0]            dest_lfsr, load_lfsr;
  logic [COUNT_WIDTH-1:0] enq_count;
  logic [7:0]             len_q, flit_idx;
  logic [1:0]             pat_q;
  entry_t                 mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [COUNT_WIDTH-1:0] sent_q, drop_q;
  logic                   gen, inject, full, empty;
  logic                   enq, deq, hs, last_flit, valid;
  logic [TDEST_WIDTH-1:0] uni, dest;
  entry_t                 head, new_entry;
  logic [TDATA_WIDTH-1:0] data;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign gen       = (state_q == S_RUN) && start;
  assign inject    = gen && (enq_count != num_packets) && (load_lfsr <= load);
  assign enq       = inject && !full;
  assign valid     = !empty;
  assign hs        = valid && axis_out.tready;
  assign last_flit = (flit_idx == len_q - 8'd1);
  assign deq       = hs && last_flit;
  assign head      = mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (num_packets == '0) ? S_FIN : S_RUN;
      S_RUN:   if (enq_count == num_packets) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_FIN;
      S_FIN:   state_d = S_FIN;
    endcase
  end

  // Uniform folds LFSR values >= N back into the mesh range.
  always_comb begin
    uni = dest_lfsr[TDEST_WIDTH-1:0];
    if ({1'b0, uni} >= N_W) uni = uni - N_W[TDEST_WIDTH-1:0];
    dest = uni;
    unique case (pat_q)
      2'd0: dest = uni;
      2'd1: dest = SQUARE ? TRANS_DEST : uni;
      2'd2: dest = NEIGH_DEST;
      2'd3: dest = hotspot_dest;
    endcase
    new_entry = '{dest: dest, seq: enq_count, ts: ticks};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dest_lfsr <= DEST_SEED;
      load_lfsr <= LOAD_SEED;
      enq_count <= '0;
      len_q     <= 8'd1;
      pat_q     <= 2'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      flit_idx  <= '0;
      sent_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        len_q <= (pkt_len == 8'd0) ? 8'd1 : pkt_len;
        pat_q <= pattern;
      end
      if (gen) begin
        dest_lfsr <= lfsr_next(dest_lfsr);
        load_lfsr <= lfsr_next(load_lfsr);
      end
      if (enq) begin
        wr_ptr    <= wr_ptr + 1'b1;
        enq_count <= enq_count + 1'b1;
      end
      if (inject && full) drop_q <= sat_inc(drop_q);
      if (hs) flit_idx <= last_flit ? 8'd0 : flit_idx + 8'd1;
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
        sent_q <= sat_inc(sent_q);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= new_entry;
  end

  always_comb begin
    data = '0;
    if (valid) begin
      data[HW-1:0]                = head.ts;
      data[HW +: COUNT_WIDTH]     = head.seq;
      data[HW+COUNT_WIDTH +: 8]   = flit_idx;
    end
  end

  assign axis_out.tvalid = valid;
  assign axis_out.tdata  = data;
  assign axis_out.tlast  = valid && last_flit;
  assign axis_out.tid    = valid ? TID_WIDTH'(TID) : '0;
  assign axis_out.tdest  = valid ? head.dest : '0;

  // Completion is visible as soon as the drain empties the queue.
  assign done = (state_q == S_FIN) || (state_q == S_DRAIN && empty);
  assign sent_packets = sent_q;
  assign dropped      = drop_q;

`ifdef AXIS_TG_STALL_STATS_EN
  logic [COUNT_WIDTH-1:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (valid && !axis_out.tready) stall_q <= sat_inc(stall_q);
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_axis_pattern_tg.sv
// tb_axis_pattern_tg: table-driven runs plus backpressure, reset and zero-load sequences.
// 2x2 mesh, TID=1, 128-bit tdata (timestamp 63:0, seq 95:64, flit index 103:96).
module tb_axis_pattern_tg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] load;
  logic [31:0] num_packets;
  logic [1:0]  pattern;
  logic [1:0]  hotspot_dest;
  logic [7:0]  pkt_len;
  logic [63:0] ticks = '0;
  logic        done;
  logic [31:0] sent_packets, dropped, stall_cycles;

  axis_if #(.TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(2)) axis ();

  axis_pattern_tg #(
    .TDATA_WIDTH(128), .TDEST_WIDTH(2), .TID_WIDTH(2), .TID(1),
    .NUM_ROWS(2), .NUM_COLS(2), .COUNT_WIDTH(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load),
    .num_packets(num_packets), .pattern(pattern),
    .hotspot_dest(hotspot_dest), .pkt_len(pkt_len), .ticks(ticks),
    .done(done), .sent_packets(sent_packets), .dropped(dropped),
    .stall_cycles(stall_cycles), .axis_out(axis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= ticks + 64'd1;

  typedef struct {
    logic [1:0] pattern;
    logic [1:0] hot;
    logic [7:0] len;
    int         np;
    int         exp_flits;
    int         exp_dest;
  } vec_t;

  vec_t vecs[6];
  int n_vec  = 0;
  int n_miss = 0;
  int cur    = -1;

  logic [1:0]  f_dest [64];
  logic        f_last [64];
  logic [31:0] f_seq  [64];
  logic [7:0]  f_idx  [64];
  logic [63:0] f_ts   [64];
  logic [63:0] f_tick [64];
  logic [1:0]  f_tid  [64];
  logic [23:0] f_rest [64];
  int          f_cyc  [64];
  logic [1:0]  ref_dest [16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (run %0d): got %0h want %0h", name, cur, act, exp);
    end
  endtask

  task automatic apply_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v, input bit do_reset,
                            input bit save_ref, input bit cmp_ref);
    int nf, done_cyc, len, pk, fi;
    len = (v.len == 8'd0) ? 1 : int'(v.len);
    if (do_reset) apply_reset();
    load         = 16'hFFFF;
    pattern      = v.pattern;
    hotspot_dest = v.hot;
    pkt_len      = v.len;
    num_packets  = v.np;
    axis.tready  = 1'b1;
    start        = 1'b1;
    nf = 0;
    done_cyc = -1;
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (axis.tvalid && nf < 64) begin
        f_dest[nf] = axis.tdest;
        f_last[nf] = axis.tlast;
        f_ts[nf]   = axis.tdata[63:0];
        f_seq[nf]  = axis.tdata[95:64];
        f_idx[nf]  = axis.tdata[103:96];
        f_rest[nf] = axis.tdata[127:104];
        f_tid[nf]  = axis.tid;
        f_tick[nf] = ticks;
        f_cyc[nf]  = c;
        nf++;
      end
      if (done) done_cyc = c;
    end
    start = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("flit_count", nf, v.exp_flits);
    chk("sent_packets", sent_packets, v.np);
    chk("dropped", dropped, 0);
    if (nf > 0) begin
      chk("done_latency", done_cyc, f_cyc[nf-1] + 1);
      chk("first_valid_t+1", f_tick[0], f_ts[0] + 64'd1);
    end
    for (int i = 0; i < nf; i++) begin
      pk = i / len;
      fi = i % len;
      if (v.exp_dest >= 0) chk("tdest", f_dest[i], v.exp_dest);
      chk("tlast", f_last[i], fi == len - 1);
      chk("flit_idx", f_idx[i], fi);
      chk("seq", f_seq[i], pk);
      chk("timestamp", f_ts[i], f_ts[0] + 64'(pk));
      chk("no_bubble", f_cyc[i], f_cyc[0] + i);
      chk("tid", f_tid[i], 1);
      chk("tdata_pad", f_rest[i], 0);
      if (save_ref && i < 16) ref_dest[i] = f_dest[i];
      if (cmp_ref && i < 16) chk("reseed_dest", f_dest[i], ref_dest[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    bit  have;
    int  stable_bad, nseq, nv;

    vecs[0] = '{2'd0, 2'd0, 8'd1, 16, 16, -1};
    vecs[1] = '{2'd3, 2'd2, 8'd4, 3, 12, 2};
    vecs[2] = '{2'd1, 2'd0, 8'd1, 4, 4, 2};
    vecs[3] = '{2'd2, 2'd0, 8'd2, 3, 6, 0};
    vecs[4] = '{2'd3, 2'd3, 8'd0, 5, 5, 3};
    vecs[5] = '{2'd0, 2'd0, 8'd1, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; load = 16'hFFFF; num_packets = '0;
    pattern = '0; hotspot_dest = '0; pkt_len = 8'd1; axis.tready = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata[63:0] | axis.tdata[127:64], 0);
    chk("rst_done", done, 0);
    chk("rst_counts", sent_packets | dropped | stall_cycles, 0);

    for (int k = 0; k < 6; k++) begin
      cur = k;
      run_vector(vecs[k], 1'b1, k == 0, 1'b0);
    end

    // Backpressure: 20 injecting cycles into an 8-deep queue.
    cur = 10;
    apply_reset();
    load = 16'hFFFF; pattern = 2'd3; hotspot_dest = 2'd1;
    pkt_len = 8'd1; num_packets = 100; axis.tready = 1'b0;
    start = 1'b1;
    have = 1'b0; stable_bad = 0; held = '0;
    repeat (21) begin
      @(negedge clk);
      if (axis.tvalid) begin
        if (!have) begin held = axis.tdata; have = 1'b1; end
        else if (axis.tdata !== held) stable_bad++;
      end
    end
    chk("bp_tvalid", axis.tvalid, 1);
    chk("bp_hold_stable", stable_bad, 0);
    chk("bp_head_seq", held[95:64], 0);
    chk("bp_tdest", axis.tdest, 1);
    chk("bp_dropped", dropped, 12);
`ifdef AXIS_TG_STALL_STATS_EN
    chk("bp_stall", stall_cycles, 19);
`else
    chk("bp_stall", stall_cycles, 0);
`endif
    start = 1'b0;
    axis.tready = 1'b1;
    nseq = 0;
    repeat (20) begin
      if (axis.tvalid) begin
        chk("pause_drain_seq", axis.tdata[95:64], nseq);
        nseq++;
      end
      @(negedge clk);
    end
    chk("pause_drain_count", nseq, 8);
    chk("pause_done", done, 0);
    chk("pause_dropped", dropped, 12);
    chk("pause_sent", sent_packets, 8);
    start = 1'b1;
    @(negedge clk);
    chk("resume_tvalid", axis.tvalid, 1);
    chk("resume_seq", axis.tdata[95:64], 8);
    start = 1'b0;

    // Asynchronous reset mid-run, then the same seed must replay run 0.
    cur = 11;
    apply_reset();
    load = 16'hFFFF; pattern = 2'd0; pkt_len = 8'd1;
    num_packets = 16; axis.tready = 1'b1; start = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_tvalid", axis.tvalid, 1);
    chk("pre_rst_sent", sent_packets != 0, 1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("async_tvalid", axis.tvalid, 0);
    chk("async_tdata", axis.tdata[63:0] | axis.tdata[127:64], 0);
    chk("async_tdest_tlast", {axis.tdest, axis.tlast}, 0);
    chk("async_counts", sent_packets | dropped | stall_cycles, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vector(vecs[0], 1'b0, 1'b0, 1'b1);

    // Zero load never injects.
    cur = 12;
    apply_reset();
    load = 16'h0; pattern = 2'd0; pkt_len = 8'd1;
    num_packets = 4; axis.tready = 1'b1; start = 1'b1;
    nv = 0;
    repeat (60) begin
      @(negedge clk);
      if (axis.tvalid) nv++;
    end
    chk("load0_flits", nv, 0);
    chk("load0_done", done, 0);
    chk("load0_dropped", dropped, 0);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
